// File: rtl/goal_sweep_ctrl.sv
// Sequencer for the goal-window frequency checker: debounced manual inc/dec keys plus an
// automatic home-then-step sweep that stops on the first window reporting a goal hit.
module goal_sweep_ctrl #(
  parameter int MAX_IDX     = 98,
  parameter int DEB_CYCLES  = 500000,
  parameter int SETTLE_MEAS = 2,
  parameter int TIMEOUT     = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       meas_valid,
  input  logic       goal_flag,
  output logic       goal_inc,
  output logic       goal_dec,
  output logic [6:0] win_idx,
  output logic       busy,
  output logic       done,
  output logic       locked,
  output logic       err
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(SETTLE_MEAS + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [MW-1:0] MEAS_LAST = MW'(SETTLE_MEAS - 1);
  localparam logic [6:0]    IDX_TOP   = 7'(MAX_IDX);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOME     = 3'd1;
  localparam logic [2:0] ST_HOME_GAP = 3'd2;
  localparam logic [2:0] ST_SETTLE   = 3'd3;
  localparam logic [2:0] ST_STEP     = 3'd4;
  localparam logic [2:0] ST_STEP_GAP = 3'd5;
  localparam logic [2:0] ST_FIN      = 3'd6;

  logic [2:0]    state;
  logic [1:0]    key_sync1;
  logic [1:0]    key_sync2;
  logic [1:0]    deb_lvl;
  logic [1:0]    deb_rise;
  logic [DW-1:0] deb_cnt [2];
  logic [MW-1:0] meas_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          inc_edge;
  logic          dec_edge;
  logic          pulse_active;

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_FIN);
  assign inc_edge     = deb_rise[0];
  assign dec_edge     = deb_rise[1];
  assign pulse_active = goal_inc | goal_dec;

  // Two-flop synchroniser for the raw, asynchronous key inputs (bit 0 = inc, bit 1 = dec).
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync1 <= 2'b00;
      key_sync2 <= 2'b00;
    end else begin
      key_sync1 <= {key_dec, key_inc};
      key_sync2 <= key_sync1;
    end
  end

  // A new level is accepted only after DEB_CYCLES consecutive samples that differ from the
  // accepted one; deb_rise marks the single cycle after a 0->1 acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl  <= 2'b00;
      deb_rise <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        deb_rise[i] <= 1'b0;
        if (key_sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i]  <= '0;
          deb_lvl[i]  <= key_sync2[i];
          deb_rise[i] <= key_sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Pulses and win_idx are registered together, so the checker sees each step and the
  // tracked index change in the same cycle; every pulse-issuing state is followed by a
  // state that issues none, which guarantees the low gap between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      win_idx  <= '0;
      goal_inc <= 1'b0;
      goal_dec <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      meas_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      goal_inc <= 1'b0;
      goal_dec <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state  <= ST_IDLE;
        locked <= 1'b0;
        err    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state    <= ST_HOME;
              locked   <= 1'b0;
              err      <= 1'b0;
              meas_cnt <= '0;
              tmo_cnt  <= '0;
            end else if (!pulse_active) begin
              // A manual pulse right after one still on the wire would merge in the checker.
              if (inc_edge && !dec_edge && win_idx != IDX_TOP) begin
                goal_inc <= 1'b1;
                win_idx  <= win_idx + 7'd1;
                locked   <= 1'b0;
                err      <= 1'b0;
              end else if (dec_edge && !inc_edge && win_idx != 7'd0) begin
                goal_dec <= 1'b1;
                win_idx  <= win_idx - 7'd1;
                locked   <= 1'b0;
                err      <= 1'b0;
              end
            end
          end
          ST_HOME: begin
            meas_cnt <= '0;
            tmo_cnt  <= '0;
            if (win_idx != 7'd0) begin
              goal_dec <= 1'b1;
              win_idx  <= win_idx - 7'd1;
              state    <= ST_HOME_GAP;
            end else begin
              state <= ST_SETTLE;
            end
          end
          ST_HOME_GAP: state <= ST_HOME;
          ST_SETTLE: begin
            if (meas_valid) begin
              tmo_cnt <= '0;
              if (meas_cnt == MEAS_LAST) begin
                if (goal_flag) begin
                  locked <= 1'b1;
                  state  <= ST_FIN;
                end else if (win_idx == IDX_TOP) begin
                  state <= ST_FIN;
                end else begin
                  state <= ST_STEP;
                end
              end else begin
                meas_cnt <= meas_cnt + MW'(1);
              end
            end else if (tmo_cnt == TMO_LAST) begin
              err   <= 1'b1;
              state <= ST_FIN;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          ST_STEP: begin
            goal_inc <= 1'b1;
            win_idx  <= win_idx + 7'd1;
            state    <= ST_STEP_GAP;
          end
          ST_STEP_GAP: begin
            meas_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= ST_SETTLE;
          end
          ST_FIN:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_goal_sweep_ctrl.sv
// Bench for goal_sweep_ctrl: directed and randomized key/sweep scenarios checked against
// a window-index model and pulse/timing rules derived from the checker's behaviour.
module tb_goal_sweep_ctrl;

  localparam int MAX_IDX = 98;
  localparam int TMO     = 50;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       key_inc;
  logic       key_dec;
  logic       meas_valid;
  logic       goal_flag;
  logic       goal_inc;
  logic       goal_dec;
  logic [6:0] win_idx;
  logic       busy;
  logic       done;
  logic       locked;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  // Environment / monitor state
  bit meas_en   = 1'b0;
  bit target_en = 1'b0;
  int target    = 0;
  int inc_cnt   = 0;
  int dec_cnt   = 0;
  int done_cnt  = 0;
  int overlap   = 0;
  int b2b       = 0;
  int idx_viol  = 0;

  goal_sweep_ctrl #(
    .MAX_IDX(MAX_IDX), .DEB_CYCLES(4), .SETTLE_MEAS(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .key_inc(key_inc), .key_dec(key_dec), .meas_valid(meas_valid), .goal_flag(goal_flag),
    .goal_inc(goal_inc), .goal_dec(goal_dec), .win_idx(win_idx), .busy(busy),
    .done(done), .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Measurement source: a strobe every 10 cycles while enabled; goal true only at target.
  initial begin
    int mcnt;
    mcnt = 0;
    meas_valid = 1'b0;
    goal_flag  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (meas_en) begin
        mcnt++;
        meas_valid = (mcnt % 10 == 0);
      end else begin
        meas_valid = 1'b0;
      end
      goal_flag = target_en && (int'(win_idx) == target);
    end
  end

  // Pulse monitor: counts steps and records rule violations for later checks.
  initial begin
    bit prev_pulse;
    bit prev_rst;
    int prev_idx;
    prev_pulse = 1'b0;
    prev_rst   = 1'b1;
    prev_idx   = 0;
    forever begin
      @(negedge clk);
      if (goal_inc) inc_cnt++;
      if (goal_dec) dec_cnt++;
      if (done) done_cnt++;
      if (goal_inc && goal_dec) overlap++;
      if ((goal_inc || goal_dec) && prev_pulse) b2b++;
      if (!rst && !prev_rst && int'(win_idx) != prev_idx + int'(goal_inc) - int'(goal_dec))
        idx_viol++;
      prev_pulse = goal_inc || goal_dec;
      prev_rst   = rst;
      prev_idx   = int'(win_idx);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic apply_keys(input bit do_inc, input bit do_dec, input int hold, input int rel);
    key_inc = do_inc;
    key_dec = do_dec;
    repeat (hold) tick();
    key_inc = 1'b0;
    key_dec = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic pulse_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic wait_idx(input int value, input int budget);
    int c;
    c = 0;
    while (int'(win_idx) != value && c < budget) begin
      tick();
      c++;
    end
  endtask

  initial begin
    int  model_idx;
    int  inc0, dec0, done0;
    int  cyc;
    bit  seen;
    bit  do_inc;
    int  exp_lat;

    rst = 1'b1; start = 1'b0; abort = 1'b0; key_inc = 1'b0; key_dec = 1'b0;

    // Reset state
    repeat (3) tick();
    check_output("rst_goal_inc", goal_inc, 0);
    check_output("rst_goal_dec", goal_dec, 0);
    check_output("rst_win_idx", win_idx, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_locked", locked, 0);
    check_output("rst_err", err, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Bouncy key_inc followed by a clean hold: a single step
    inc0 = inc_cnt;
    apply_keys(1'b1, 1'b0, 2, 2);
    apply_keys(1'b1, 1'b0, 2, 2);
    apply_keys(1'b1, 1'b0, 8, 12);
    check_output("bounce_inc_pulses", inc_cnt - inc0, 1);
    check_output("bounce_idx", win_idx, 1);

    // Back to 0, then dec saturates; simultaneous keys ignored
    dec0 = dec_cnt;
    apply_keys(1'b0, 1'b1, 8, 12);
    check_output("dec_to0_idx", win_idx, 0);
    apply_keys(1'b0, 1'b1, 8, 12);
    check_output("dec_sat_pulses", dec_cnt - dec0, 1);
    check_output("dec_sat_idx", win_idx, 0);
    inc0 = inc_cnt;
    apply_keys(1'b1, 1'b1, 8, 12);
    check_output("both_keys_inc", inc_cnt - inc0, 0);
    check_output("both_keys_idx", win_idx, 0);

    // Randomized manual presses against a saturating index model
    model_idx = 0;
    for (int i = 0; i < 16; i++) begin
      do_inc = ($urandom_range(0, 3) != 0);
      apply_keys(do_inc, !do_inc, $urandom_range(6, 12), $urandom_range(10, 15));
      if (do_inc) model_idx = (model_idx < MAX_IDX) ? model_idx + 1 : model_idx;
      else        model_idx = (model_idx > 0) ? model_idx - 1 : 0;
      check_output("rand_manual_idx", win_idx, model_idx);
    end
    while (model_idx != 5) begin
      do_inc = (model_idx < 5);
      apply_keys(do_inc, !do_inc, 8, 12);
      model_idx = do_inc ? model_idx + 1 : model_idx - 1;
    end
    check_output("pre_sweep_idx", win_idx, 5);

    // Hit sweep from idx 5, goal only at idx 3
    meas_en = 1'b1; target = 3; target_en = 1'b1;
    inc0 = inc_cnt; dec0 = dec_cnt; done0 = done_cnt;
    pulse_start(1'b0);
    check_output("hit_busy", busy, 1);
    wait_done(3000, cyc, seen);
    check_output("hit_done_seen", seen, 1);
    check_output("hit_locked", locked, 1);
    check_output("hit_err", err, 0);
    check_output("hit_idx", win_idx, 3);
    check_output("hit_dec_pulses", dec_cnt - dec0, 5);
    check_output("hit_inc_pulses", inc_cnt - inc0, 3);
    tick();
    check_output("hit_idle", busy, 0);
    check_output("hit_done_count", done_cnt - done0, 1);

    // No-hit sweep to the top window
    target_en = 1'b0;
    inc0 = inc_cnt; dec0 = dec_cnt;
    pulse_start(1'b0);
    wait_done(6000, cyc, seen);
    check_output("top_done_seen", seen, 1);
    check_output("top_idx", win_idx, MAX_IDX);
    check_output("top_locked", locked, 0);
    check_output("top_err", err, 0);
    check_output("top_inc_pulses", inc_cnt - inc0, MAX_IDX);
    check_output("top_dec_pulses", dec_cnt - dec0, 3);
    tick();
    inc0 = inc_cnt;
    apply_keys(1'b1, 1'b0, 8, 12);
    check_output("top_sat_pulses", inc_cnt - inc0, 0);
    check_output("top_sat_idx", win_idx, MAX_IDX);

    // Abort in SETTLE at idx 7
    done0 = done_cnt;
    pulse_start(1'b0);
    wait_idx(0, 400);
    check_output("abort_homed", win_idx, 0);
    wait_idx(7, 400);
    check_output("abort_reach7", win_idx, 7);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_idx", win_idx, 7);
    inc0 = inc_cnt; dec0 = dec_cnt;
    repeat (30) tick();
    check_output("abort_no_pulses", (inc_cnt - inc0) + (dec_cnt - dec0), 0);
    check_output("abort_no_done", done_cnt - done0, 0);
    check_output("abort_idx_hold", win_idx, 7);
    pulse_start(1'b1);
    check_output("start_abort_busy", busy, 0);
    repeat (3) tick();
    check_output("start_abort_idle", busy, 0);

    // Timeout: no measurements; done expected 2 + 2*idx + TIMEOUT cycles after start
    meas_en = 1'b0;
    repeat (2) tick();
    pulse_start(1'b0);
    wait_done(400, cyc, seen);
    exp_lat = 2 + 2 * 7 + TMO;
    check_output("tmo_done_seen", seen, 1);
    check_output("tmo_latency", cyc + 1, exp_lat);
    check_output("tmo_err", err, 1);
    check_output("tmo_locked", locked, 0);
    check_output("tmo_idx", win_idx, 0);
    tick();
    apply_keys(1'b1, 1'b0, 8, 12);
    check_output("manual_clears_err", err, 0);
    check_output("manual_after_tmo_idx", win_idx, 1);

    // Randomized hit target from idx 1
    meas_en = 1'b1;
    target = $urandom_range(2, 25);
    target_en = 1'b1;
    inc0 = inc_cnt; dec0 = dec_cnt;
    pulse_start(1'b0);
    wait_done(2000, cyc, seen);
    check_output("rand_hit_seen", seen, 1);
    check_output("rand_hit_idx", win_idx, target);
    check_output("rand_hit_locked", locked, 1);
    check_output("rand_hit_inc", inc_cnt - inc0, target);
    check_output("rand_hit_dec", dec_cnt - dec0, 1);
    tick();

    // Reset mid-sweep
    target_en = 1'b0;
    pulse_start(1'b0);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check_output("midrst_busy", busy, 0);
    check_output("midrst_idx", win_idx, 0);
    check_output("midrst_locked", locked, 0);
    check_output("midrst_pulses", goal_inc | goal_dec, 0);
    rst = 1'b0;
    repeat (3) tick();
    check_output("midrst_done", done, 0);

    // Global pulse rules
    check_output("pulse_overlap", overlap, 0);
    check_output("pulse_back_to_back", b2b, 0);
    check_output("idx_tracks_pulses", idx_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
